// File: rtl/ccip_tx_flow_scheduler.sv
// CCI-P transmit batch scheduler: round-robin full-batch grants across active flows,
// with age-based flushing of partial batches and c1 almost-full backpressure.
module ccip_tx_flow_scheduler #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LTX_FIFO_DEPTH    = 3,
  parameter int LMAX_CCIP_BATCH   = 2,
  parameter int TIMEOUT_W         = 16
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                    number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]                      l_tx_batch_size,
  input  logic [TIMEOUT_W-1:0]                            flush_timeout,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*LTX_FIFO_DEPTH-1:0] ff_dw_in,
  input  logic                                            sRx_c1TxAlmFull,
  output logic                                            grant_valid_out,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                    grant_flow_out,
  output logic [LMAX_CCIP_BATCH:0]                        grant_len_out,
  input  logic                                            grant_done_in,
  output logic                                            busy_out,
  output logic [31:0]                                     flush_cnt_out
);

  localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int LW        = LMAX_CCIP_BATCH + 1;
  localparam int CW        = (LTX_FIFO_DEPTH > LW) ? LTX_FIFO_DEPTH : LW;

  typedef enum logic [1:0] {SIdle, SScan, SGrant, SWait} state_t;

  state_t                       state, state_nxt;
  logic [LMAX_NUM_OF_FLOWS-1:0] ptr, ptr_nxt, grant_flow;
  logic [LW-1:0]                grant_len, take_len;
  logic                         grant_is_flush, take, take_flush;
  logic [31:0]                  flush_cnt;
  logic [TIMEOUT_W-1:0]         age [MAX_FLOWS];
  logic [LTX_FIFO_DEPTH-1:0]    dw  [MAX_FLOWS];
  logic [LMAX_CCIP_BATCH-1:0]   l_eff;
  logic [LW-1:0]                batch_len, flush_len;
  logic [CW-1:0]                dw_p, batch_ext, avail;
  logic                         eligible, full_hit, flush_hit;

  function automatic logic [LMAX_NUM_OF_FLOWS-1:0] next_ptr(
    input logic [LMAX_NUM_OF_FLOWS-1:0] p,
    input logic [LMAX_NUM_OF_FLOWS-1:0] last
  );
    return (p >= last) ? '0 : p + LMAX_NUM_OF_FLOWS'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < MAX_FLOWS; i++) begin
      dw[i] = ff_dw_in[i*LTX_FIFO_DEPTH +: LTX_FIFO_DEPTH];
    end
  end

  // Decision terms for the flow under the pointer; flush length is the largest
  // power of two that fits in what the flow holds, capped at the batch size.
  always_comb begin
    l_eff     = (int'(l_tx_batch_size) > 2) ? LMAX_CCIP_BATCH'(2) : l_tx_batch_size;
    batch_len = LW'(1) << l_eff;
    dw_p      = CW'(dw[ptr]);
    batch_ext = CW'(batch_len);
    avail     = (dw_p < batch_ext) ? dw_p : batch_ext;
    flush_len = LW'(1);
    for (int k = 1; k < LW; k++) begin
      if (avail >= (CW'(1) << k)) flush_len = LW'(1) << k;
    end
    eligible  = (ptr <= number_of_flows);
    full_hit  = eligible && (dw_p >= batch_ext);
    flush_hit = eligible && (flush_timeout != '0) && (dw_p != '0) &&
                (age[ptr] >= flush_timeout);
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    take       = 1'b0;
    take_flush = 1'b0;
    take_len   = '0;
    case (state)
      SIdle: if (start) state_nxt = SScan;
      SScan: begin
        if (!start) begin
          state_nxt = SIdle;
        end else if (sRx_c1TxAlmFull) begin
          state_nxt = SScan;
        end else if (full_hit) begin
          take      = 1'b1;
          take_len  = batch_len;
          state_nxt = SGrant;
        end else if (flush_hit) begin
          take       = 1'b1;
          take_flush = 1'b1;
          take_len   = flush_len;
          state_nxt  = SGrant;
        end else begin
          ptr_nxt = next_ptr(ptr, number_of_flows);
        end
      end
      SGrant: state_nxt = SWait;
      SWait: begin
        if (grant_done_in) begin
          ptr_nxt   = next_ptr(grant_flow, number_of_flows);
          state_nxt = start ? SScan : SIdle;
        end
      end
      default: state_nxt = SIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SIdle;
      ptr            <= '0;
      grant_flow     <= '0;
      grant_len      <= '0;
      grant_is_flush <= 1'b0;
      flush_cnt      <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (take) begin
        grant_flow     <= ptr;
        grant_len      <= take_len;
        grant_is_flush <= take_flush;
      end
      if (state == SGrant && grant_is_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  // Ages restart on grant and hold while the flow is being popped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_FLOWS; i++) begin
      if (reset) begin
        age[i] <= '0;
      end else if (dw[i] == '0) begin
        age[i] <= '0;
      end else if (state == SGrant && grant_flow == LMAX_NUM_OF_FLOWS'(i)) begin
        age[i] <= '0;
      end else if (state == SWait && grant_flow == LMAX_NUM_OF_FLOWS'(i)) begin
        age[i] <= age[i];
      end else if (age[i] != '1) begin
        age[i] <= age[i] + TIMEOUT_W'(1);
      end
    end
  end

  assign grant_valid_out = (state == SGrant);
  assign grant_flow_out  = grant_flow;
  assign grant_len_out   = grant_len;
  assign busy_out        = (state == SGrant) || (state == SWait);
  assign flush_cnt_out   = flush_cnt;

endmodule
